// File: rtl/element_delay_settler_pkg.sv
// element_delay_settler_pkg: shared widths, K term type and settle FSM states
package element_delay_settler_pkg;
  localparam int DEF_DW_INTEGER = 18;
  localparam int DEF_DW_FRACTION = 6;
  localparam int DW_COUNTER = 7;
  typedef logic signed [DEF_DW_INTEGER+DEF_DW_FRACTION-1:0] term_t;
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_TERM = 3'd1,
    S_SETTLE    = 3'd2,
    S_OUTPUT    = 3'd3,
    S_DONE      = 3'd4
  } settle_state_t;
endpackage

// File: rtl/element_delay_settler_isqrt_step.sv
// isqrt_step: one +-1 integer-sqrt settling step on (t, e = S - t^2) with settled/underflow/saturate flags
module isqrt_step #(
  parameter int DW_INTEGER = 18,
  parameter int DW_FRACTION = 6
) (
  input  logic [DW_INTEGER-1:0]                    t,
  input  logic signed [DW_INTEGER+DW_FRACTION+1:0] e,
  output logic [DW_INTEGER-1:0]                    t_next,
  output logic signed [DW_INTEGER+DW_FRACTION+1:0] e_next,
  output logic                                     settled,
  output logic                                     underflow,
  output logic                                     saturate
);
  logic signed [DW_INTEGER+DW_FRACTION+1:0] inc, dec;
  logic up, down, zero;
  assign inc = $signed({{(DW_FRACTION+1){1'b0}}, t, 1'b1}) <<< DW_FRACTION;
  assign dec = $signed({{(DW_FRACTION+1){1'b0}}, t - DW_INTEGER'(1), 1'b1}) <<< DW_FRACTION;
  assign zero = t == '0;
  assign up = e >= inc;
  assign down = e[DW_INTEGER+DW_FRACTION+1];
  assign saturate = up & (&t);
  assign underflow = down & zero;
  assign settled = !up & !down;
  assign t_next = saturate ? t : up ? t + DW_INTEGER'(1) : (down && !zero) ? t - DW_INTEGER'(1) : t;
  assign e_next = saturate ? e : up ? e - inc : down ? (zero ? '0 : e + dec) : e;
endmodule

// File: rtl/element_delay_settler.sv
// element_delay_settler: consumes K_n pairs, settles per-side integer sqrt delays, streams (element_n, delay_pos_n, delay_neg_n) with valid/ack
module element_delay_settler import element_delay_settler_pkg::*; #(
  parameter int DW_INTEGER = DEF_DW_INTEGER,
  parameter int DW_FRACTION = DEF_DW_FRACTION,
  parameter int NUM_ELEMENTS = 64,
  parameter int MAX_STEPS = 64
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                initiate,
  input  logic [DW_INTEGER-1:0]               tau_0,
  input  logic signed [DW_INTEGER+DW_FRACTION-1:0] term_pos_n,
  input  logic signed [DW_INTEGER+DW_FRACTION-1:0] term_neg_n,
  input  logic                                term_ready,
  input  logic                                term_last,
  output logic                                term_ack,
  output logic [DW_INTEGER-1:0]               delay_pos_n,
  output logic [DW_INTEGER-1:0]               delay_neg_n,
  output logic [DW_COUNTER-1:0]               element_n,
  output logic                                delay_valid,
  input  logic                                delay_ack,
  output logic                                busy,
  output logic                                done,
  output logic                                error
);
  localparam int EW = DW_INTEGER + DW_FRACTION + 2;
  settle_state_t state;
  logic [DW_INTEGER-1:0] t_p, t_n, tn_p, tn_n;
  logic signed [EW-1:0] e_p, e_n, en_p, en_n;
  logic set_p, set_n, uf_p, uf_n, sat_p, sat_n, last;
  logic [DW_COUNTER-1:0] cnt;
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
  isqrt_step #(.DW_INTEGER(DW_INTEGER), .DW_FRACTION(DW_FRACTION)) u_pos (
    .t(t_p), .e(e_p), .t_next(tn_p), .e_next(en_p), .settled(set_p), .underflow(uf_p), .saturate(sat_p));
  isqrt_step #(.DW_INTEGER(DW_INTEGER), .DW_FRACTION(DW_FRACTION)) u_neg (
    .t(t_n), .e(e_n), .t_next(tn_n), .e_next(en_n), .settled(set_n), .underflow(uf_n), .saturate(sat_n));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      {t_p, t_n, e_p, e_n, cnt, last} <= '0;
      {term_ack, delay_pos_n, delay_neg_n, element_n, delay_valid, error} <= '0;
    end else begin
      case (state)
        S_IDLE: if (initiate) begin
          t_p <= tau_0;
          t_n <= tau_0;
          e_p <= '0;
          e_n <= '0;
          element_n <= '0;
          error <= 1'b0;
          state <= S_WAIT_TERM;
        end
        S_WAIT_TERM: if (term_ready && !term_ack) begin
          e_p <= e_p + EW'(term_pos_n);
          e_n <= e_n + EW'(term_neg_n);
          last <= term_last;
          term_ack <= 1'b1;
          cnt <= '0;
          state <= S_SETTLE;
        end
        S_SETTLE: begin
          term_ack <= 1'b0;
          if ((set_p && set_n) || cnt == DW_COUNTER'(MAX_STEPS)) begin
            error <= error | !(set_p && set_n);
            element_n <= element_n + DW_COUNTER'(1);
            state <= S_OUTPUT;
          end else begin
            {t_p, e_p, t_n, e_n} <= {tn_p, en_p, tn_n, en_n};
            cnt <= cnt + DW_COUNTER'(1);
            error <= error | uf_p | uf_n | sat_p | sat_n;
          end
        end
        S_OUTPUT: if (!delay_valid) begin
          delay_valid <= 1'b1;
          delay_pos_n <= t_p;
          delay_neg_n <= t_n;
        end else if (delay_ack) begin
          delay_valid <= 1'b0;
          state <= (last || element_n == DW_COUNTER'(NUM_ELEMENTS / 2)) ? S_DONE : S_WAIT_TERM;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_element_delay_settler.sv
// tb_element_delay_settler: directed self-checking bench for element_delay_settler
module tb_element_delay_settler;
  import element_delay_settler_pkg::*;
  logic clk = 1'b0, rst = 1'b1, initiate = 1'b0, initiate8 = 1'b0;
  logic term_ready = 1'b0, term_last = 1'b0, delay_ack = 1'b0;
  logic [17:0] tau_0 = '0;
  term_t term_pos_n = '0, term_neg_n = '0;
  logic term_ack, delay_valid, busy, done, error;
  logic term_ack8, delay_valid8, busy8, done8, error8;
  logic [17:0] delay_pos_n, delay_neg_n, delay_pos8, delay_neg8;
  logic [6:0] element_n, element8;
  int n_asserts = 0, n_fail = 0, acks = 0, dones = 0;

  element_delay_settler dut (
    .clk(clk), .rst(rst), .initiate(initiate), .tau_0(tau_0),
    .term_pos_n(term_pos_n), .term_neg_n(term_neg_n), .term_ready(term_ready), .term_last(term_last),
    .term_ack(term_ack), .delay_pos_n(delay_pos_n), .delay_neg_n(delay_neg_n), .element_n(element_n),
    .delay_valid(delay_valid), .delay_ack(delay_ack), .busy(busy), .done(done), .error(error));

  element_delay_settler #(.MAX_STEPS(8)) dut8 (
    .clk(clk), .rst(rst), .initiate(initiate8), .tau_0(tau_0),
    .term_pos_n(term_pos_n), .term_neg_n(term_neg_n), .term_ready(term_ready), .term_last(term_last),
    .term_ack(term_ack8), .delay_pos_n(delay_pos8), .delay_neg_n(delay_neg8), .element_n(element8),
    .delay_valid(delay_valid8), .delay_ack(delay_ack), .busy(busy8), .done(done8), .error(error8));

  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (term_ack) acks++;
    if (done) dones++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [17:0] tau);
    tau_0 = tau;
    initiate = 1'b1;
    tick();
    initiate = 1'b0;
    chk("busy_after_initiate", busy, 1);
  endtask

  task automatic send_term(input int p, input int n, input logic l);
    int k = 0;
    term_pos_n = term_t'(p);
    term_neg_n = term_t'(n);
    term_last = l;
    term_ready = 1'b1;
    do begin
      tick();
      k++;
    end while (!term_ack && k < 50);
    chk("term_ack_seen", term_ack, 1);
    term_ready = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int lat, input int p, input int n, input int el);
    int k = 0;
    while (!delay_valid && k < 200) begin
      tick();
      k++;
    end
    chk({tag, "_latency"}, k, lat);
    chk({tag, "_delay_pos"}, delay_pos_n, p);
    chk({tag, "_delay_neg"}, delay_neg_n, n);
    chk({tag, "_element"}, element_n, el);
  endtask

  task automatic ack_out();
    delay_ack = 1'b1;
    tick();
    delay_ack = 1'b0;
    chk("valid_drop_after_ack", delay_valid, 0);
  endtask

  initial begin
    int k, a0, d0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_valid", delay_valid, 0);
    chk("reset_term_ack", term_ack, 0);
    chk("reset_delay_pos", delay_pos_n, 0);
    chk("reset_element", element_n, 0);
    chk("reset_done", done, 0);
    chk("reset_error", error, 0);
    // one-step element on the positive side, zero-step on the negative side
    start(100);
    send_term(201 << 6, 0, 1'b1);
    wait_out("t1", 3, 101, 100, 1);
    ack_out();
    chk("t1_done_pulse", done, 1);
    tick();
    chk("t1_done_low", done, 0);
    chk("t1_idle", busy, 0);
    chk("t1_error", error, 0);
    // four steps up on pos, one step down on neg
    start(100);
    send_term(1000 << 6, -(199 << 6), 1'b1);
    wait_out("t2", 6, 104, 99, 1);
    ack_out();
    tick();
    // underflow clamp on the negative side
    start(1);
    send_term(0, -(5 << 6), 1'b1);
    wait_out("uf", 4, 1, 0, 1);
    chk("uf_error", error, 1);
    ack_out();
    tick();
    chk("uf_error_holds", error, 1);
    // full frame: S_pos = (50+n)^2, S_neg = (50-n)^2
    start(50);
    chk("frame_error_cleared", error, 0);
    a0 = acks;
    d0 = dones;
    for (int n = 1; n <= 32; n++) begin
      send_term((2 * (50 + n) - 1) << 6, -((2 * (50 - n) + 1) << 6), n == 32);
      wait_out("frame", 3, 50 + n, 50 - n, n);
      ack_out();
    end
    tick();
    tick();
    chk("frame_ack_count", acks - a0, 32);
    chk("frame_done_count", dones - d0, 1);
    chk("frame_idle", busy, 0);
    chk("frame_error", error, 0);
    // back-pressure: ack held low while the next term is already offered
    start(100);
    send_term(201 << 6, 0, 1'b0);
    wait_out("bp1", 3, 101, 100, 1);
    term_pos_n = term_t'(203 << 6);
    term_neg_n = term_t'(201 << 6);
    term_last = 1'b1;
    term_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid_held", delay_valid, 1);
      chk("bp_pos_stable", delay_pos_n, 101);
      chk("bp_neg_stable", delay_neg_n, 100);
      chk("bp_no_term_ack", term_ack, 0);
    end
    ack_out();
    send_term(203 << 6, 201 << 6, 1'b1);
    wait_out("bp2", 3, 102, 101, 2);
    ack_out();
    tick();
    // step limit on the MAX_STEPS=8 instance plus underflow on its negative side
    tau_0 = 1;
    initiate8 = 1'b1;
    tick();
    initiate8 = 1'b0;
    term_pos_n = term_t'(5000 << 6);
    term_neg_n = term_t'(-(5 << 6));
    term_last = 1'b1;
    term_ready = 1'b1;
    k = 0;
    do begin
      tick();
      k++;
    end while (!term_ack8 && k < 50);
    chk("lim_term_ack", term_ack8, 1);
    term_ready = 1'b0;
    k = 0;
    while (!delay_valid8 && k < 200) begin
      tick();
      k++;
    end
    chk("lim_latency", k, 10);
    chk("lim_delay_pos", delay_pos8, 9);
    chk("lim_delay_neg", delay_neg8, 0);
    chk("lim_element", element8, 1);
    chk("lim_error", error8, 1);
    delay_ack = 1'b1;
    tick();
    delay_ack = 1'b0;
    chk("lim_done", done8, 1);
    tick();
    chk("lim_idle", busy8, 0);
    chk("main_untouched", busy, 0);
    // reset in the middle of a long settle
    start(1);
    send_term(5000 << 6, 0, 1'b1);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_term_ack", term_ack, 0);
    chk("rst_valid", delay_valid, 0);
    chk("rst_delay_pos", delay_pos_n, 0);
    chk("rst_delay_neg", delay_neg_n, 0);
    chk("rst_element", element_n, 0);
    chk("rst_error", error, 0);
    chk("rst_done", done, 0);
    start(100);
    send_term(201 << 6, 0, 1'b1);
    wait_out("rst_frame", 3, 101, 100, 1);
    ack_out();
    chk("rst_frame_done", done, 1);
    chk("rst_frame_error", error, 0);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end
endmodule
